fft_addr_ctrl: RTL and testbench
================================

Name: fft_addr_ctrl

Overview:
- Sequencing controller for the 256-point radix-2 in-place DIF FFT.
- For every stage and every butterfly it issues:
  - the two data-memory read addresses,
  - the matching twiddle index (drives the twiddle ROM `cw_addr`, 7 bits, W_N^k for k = 0..127),
  - the same two write-back addresses, delayed by the butterfly pipeline latency.
- Inserts a drain gap between stages so in-place writes of stage s complete before stage s+1 reads.

Parameters:
- N, 256, FFT length (power of 2, ≥ 4).
- LOG2N, 8, log2(N), which is also the number of stages.
- PIPE_LAT, 4, cycles from read issue to write-back in the butterfly datapath (≥ 1).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a transform; sampled only in IDLE
- busy  output  1  high in RUN and DRAIN
- done  output  1  one-cycle pulse when the transform completes
- stage  output  LOG2N bits (3 used)  current stage index 0..LOG2N-1
- rd_en  output  1  butterfly read issue
- rd_addr_a  output  LOG2N  upper-leg data address
- rd_addr_b  output  LOG2N  lower-leg data address
- cw_addr  output  LOG2N-1  twiddle ROM index, aligned with rd_addr_*
- wr_en  output  1  butterfly write-back
- wr_addr_a  output  LOG2N  write address, upper leg
- wr_addr_b  output  LOG2N  write address, lower leg

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-low. While reset = 0, all outputs are 0, the state is IDLE, and all counters and the delay line are cleared.
- States and transitions:
  - IDLE → RUN when start = 1.
  - RUN → DRAIN after the butterfly with b = N/2-1.
  - DRAIN → RUN (stage+1) after PIPE_LAT cycles, if stage < LOG2N-1.
  - DRAIN → DONE after PIPE_LAT cycles, if stage = LOG2N-1.
  - DONE → IDLE unconditionally.
- RUN:
  - Each cycle rd_en = 1 with butterfly counter b = 0..N/2-1.
  - span = N >> (s+1); grp = b >> (LOG2N-1-s); pos = b & (span-1).
  - rd_addr_a = grp·2·span + pos; rd_addr_b = rd_addr_a + span; cw_addr = pos << s.
  - All address outputs are registered from the state and counters and are valid in the same cycle as rd_en.
  - cw_addr never exceeds N/2-1; no wrap is possible.
- Write-back delay line:
  - wr_en, wr_addr_a and wr_addr_b equal rd_en, rd_addr_a and rd_addr_b delayed exactly PIPE_LAT cycles.
  - The delay line shifts every cycle in every state; it is not stalled.
- DRAIN:
  - rd_en = 0; cw_addr holds 0; a counter runs PIPE_LAT cycles.
  - The last write of a stage falls in the final DRAIN cycle.
  - The first read of the next stage occurs the following cycle, so no read-after-write overlap.
- DONE: done = 1 for exactly one cycle; busy = 0; stage returns to 0 on entry to IDLE.
- Outputs in IDLE and DONE: rd_en = 0 and wr_en = 0; address outputs are 0.
- Latency:
  - start sampled at edge k → first rd_en in cycle k+1.
  - done asserts LOG2N·(N/2+PIPE_LAT) cycles after the first rd_en; this is 1056 for the default parameters.
- Boundary conditions:
  - start while not IDLE is ignored.
  - start in DONE is ignored; a new start is accepted only once back in IDLE.
  - Reset mid-transform aborts immediately: no further wr_en, and done is not pulsed.
  - stage changes only on the DRAIN → RUN transition.

Decomposition:
- fft_pkg holds: N, LOG2N, PIPE_LAT defaults, address-width constants, and the state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, fft_wr_delay: a parameterised PIPE_LAT-deep shift register of {en, addr_a, addr_b} with asynchronous active-low reset.
- The address arithmetic stays inline in fft_addr_ctrl.

Test Plan:
- Reset held low, toggle start → all outputs 0; busy stays 0; release reset with start = 0 → remains IDLE.
- start pulse, stage 0 → b = 0: a = 0, b = 128, cw = 0; b = 5: a = 5, b = 133, cw = 5; b = 127: a = 127, b = 255, cw = 127.
- Stage 1 → b = 64: a = 128, b = 192, cw = 0; b = 70: a = 134, b = 198, cw = 12. Stage 7 → b = 3: a = 6, b = 7, cw = 0.
- Full run:
  - the wr_* stream equals the rd_* stream shifted 4 cycles;
  - 4 rd_en-free cycles between stages;
  - no wr to an address after a next-stage rd of it;
  - done pulses once, 1056 cycles after the first rd_en;
  - 1024 total rd_en cycles.
- start pulses during RUN, DRAIN and DONE → ignored; the cycle count is unchanged; a second start after IDLE repeats an identical sequence.
- reset asserted during stage 3 DRAIN → outputs 0 immediately; no done pulse; the next start begins at stage 0, b = 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the 256-point radix-2 DIF FFT sequencer.
package fft_pkg;

  // Default transform geometry and butterfly pipeline depth.
  localparam int N_DEF        = 256;
  localparam int LOG2N_DEF    = 8;
  localparam int PIPE_LAT_DEF = 4;

  // Data-memory address width for the default geometry.
  localparam int ADDR_W_DEF   = LOG2N_DEF;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage : fft_pkg

// File: rtl/fft_wr_delay.sv
// Write-back delay line: replays the read-issue stream {en, addr_a, addr_b}
// DEPTH cycles later so write addresses line up with butterfly results.
module fft_wr_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = PIPE_LAT_DEF,
  parameter int AW    = ADDR_W_DEF
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          en_i,
  input  logic [AW-1:0] addr_a_i,
  input  logic [AW-1:0] addr_b_i,
  output logic          en_o,
  output logic [AW-1:0] addr_a_o,
  output logic [AW-1:0] addr_b_o
);

  typedef struct packed {
    logic          en;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } slot_t;

  slot_t pipe_q [DEPTH];

  // Shift one slot per cycle in every state; the line is never stalled.
  // NOTE: sequential state uses non-blocking assignments so every slot
  // samples its neighbour's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: this small array is reset deliberately -- a stale enable left
      // in the line would fire a spurious write after a mid-transform abort.
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{en: en_i, a: addr_a_i, b: addr_b_i};
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign en_o     = pipe_q[DEPTH-1].en;
  assign addr_a_o = pipe_q[DEPTH-1].a;
  assign addr_b_o = pipe_q[DEPTH-1].b;

endmodule : fft_wr_delay

// File: rtl/fft_addr_ctrl.sv
// Address sequencer for an in-place radix-2 DIF FFT. Walks every stage and
// butterfly, issuing the two read addresses and the twiddle index, then
// replays the read addresses as write-back addresses after the butterfly
// latency. A drain gap per stage keeps stage s+1 reads behind stage s writes.
module fft_addr_ctrl
  import fft_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOG2N    = LOG2N_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LOG2N-1:0] stage_o,
  output logic             rd_en_o,
  output logic [LOG2N-1:0] rd_addr_a_o,
  output logic [LOG2N-1:0] rd_addr_b_o,
  output logic [LOG2N-2:0] cw_addr_o,
  output logic             wr_en_o,
  output logic [LOG2N-1:0] wr_addr_a_o,
  output logic [LOG2N-1:0] wr_addr_b_o
);

  localparam int SW = $clog2(LOG2N);                            // stage index
  localparam int BW = LOG2N - 1;                                // butterfly index
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;    // drain counter

  localparam logic [BW-1:0] B_LAST = BW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  state_e          state_q;
  logic [SW-1:0]   stage_q;
  logic [BW-1:0]   bfly_q;
  logic [DW-1:0]   drain_q;
  logic            busy_q;
  logic            done_q;
  logic            rd_en_q;
  logic [LOG2N-1:0] rd_addr_a_q;
  logic [LOG2N-1:0] rd_addr_b_q;
  logic [BW-1:0]   cw_addr_q;

  // (stage, butterfly) pair that will be issued if the FSM issues a read at
  // the coming edge, and the addresses derived from it.
  logic [SW-1:0]    iss_stage_d;
  logic [BW-1:0]    iss_bfly_d;
  logic [SW-1:0]    shamt;
  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] grp;
  logic [BW-1:0]    pos_mask;
  logic [BW-1:0]    pos;
  logic [LOG2N-1:0] iss_a_d;
  logic [LOG2N-1:0] iss_b_d;
  logic [BW-1:0]    iss_cw_d;

  // Select the next butterfly to issue: continue the current stage, open the
  // next stage after a drain, or begin stage 0 from idle.
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    iss_stage_d = stage_q;
    iss_bfly_d  = bfly_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        iss_stage_d = '0;
        iss_bfly_d  = '0;
      end
      ST_DRAIN: begin
        iss_stage_d = stage_q + 1'b1;
        iss_bfly_d  = '0;
      end
      default: ;
    endcase
  end

  // Butterfly address arithmetic. For stage s the half-span is 2^(LOG2N-1-s):
  // the butterfly index splits into a group number (high bits) and a position
  // inside the group (low bits). Spreading the group bits up by one place
  // leaves room for the lower leg at +span; the twiddle index is pos << s.
  always_comb begin
    shamt    = S_LAST - iss_stage_d;
    span     = LOG2N'(1) << shamt;
    grp      = {1'b0, iss_bfly_d} >> shamt;
    // At stage 0 the shift pushes every bit out, so the mask is all ones.
    pos_mask = ~({BW{1'b1}} << shamt);
    pos      = iss_bfly_d & pos_mask;
    iss_a_d  = ((grp << shamt) << 1) | {1'b0, pos};
    iss_b_d  = iss_a_d + span;
    iss_cw_d = pos << iss_stage_d;
  end

  // Sequencer FSM with registered read-side outputs. Read outputs default to
  // zero each cycle and are loaded only on cycles that issue a butterfly.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      bfly_q      <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      cw_addr_q   <= '0;
    end else begin
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      cw_addr_q   <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            stage_q     <= iss_stage_d;
            bfly_q      <= iss_bfly_d;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= iss_a_d;
            rd_addr_b_q <= iss_b_d;
            cw_addr_q   <= iss_cw_d;
          end
        end
        ST_RUN: begin
          if (bfly_q == B_LAST) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end else begin
            bfly_q      <= iss_bfly_d;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= iss_a_d;
            rd_addr_b_q <= iss_b_d;
            cw_addr_q   <= iss_cw_d;
          end
        end
        ST_DRAIN: begin
          if (drain_q != D_LAST) begin
            drain_q <= drain_q + 1'b1;
          end else if (stage_q == S_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            // The last write of this stage lands in this cycle, so the next
            // stage's first read can issue right after the edge.
            state_q     <= ST_RUN;
            stage_q     <= iss_stage_d;
            bfly_q      <= iss_bfly_d;
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= iss_a_d;
            rd_addr_b_q <= iss_b_d;
            cw_addr_q   <= iss_cw_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          stage_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          stage_q <= '0;
        end
      endcase
    end
  end

  fft_wr_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (LOG2N)
  ) u_wr_delay (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (rd_en_q),
    .addr_a_i (rd_addr_a_q),
    .addr_b_i (rd_addr_b_q),
    .en_o     (wr_en_o),
    .addr_a_o (wr_addr_a_o),
    .addr_b_o (wr_addr_b_o)
  );

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign stage_o     = {{(LOG2N - SW){1'b0}}, stage_q};
  assign rd_en_o     = rd_en_q;
  assign rd_addr_a_o = rd_addr_a_q;
  assign rd_addr_b_o = rd_addr_b_q;
  assign cw_addr_o   = cw_addr_q;

endmodule : fft_addr_ctrl

// File: tb/tb_fft_addr_ctrl.sv
// Self-checking bench for fft_addr_ctrl: a negedge monitor models the read
// address sequence and keeps a scoreboard of expected write-backs; the main
// thread drives start/reset scenarios and checks a table of address vectors.
module tb_fft_addr_ctrl;

  localparam int N         = 256;
  localparam int LOG2N     = 8;
  localparam int PIPE_LAT  = 4;
  localparam int STAGE_CYC = N / 2 + PIPE_LAT;
  localparam int RUN_CYC   = LOG2N * STAGE_CYC;   // 1056
  localparam int TOTAL_RD  = LOG2N * N / 2;       // 1024

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             busy_o;
  logic             done_o;
  logic [LOG2N-1:0] stage_o;
  logic             rd_en_o;
  logic [LOG2N-1:0] rd_addr_a_o;
  logic [LOG2N-1:0] rd_addr_b_o;
  logic [LOG2N-2:0] cw_addr_o;
  logic             wr_en_o;
  logic [LOG2N-1:0] wr_addr_a_o;
  logic [LOG2N-1:0] wr_addr_b_o;

  fft_addr_ctrl #(
    .N        (N),
    .LOG2N    (LOG2N),
    .PIPE_LAT (PIPE_LAT)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .start_i     (start),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .stage_o     (stage_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_a_o (rd_addr_a_o),
    .rd_addr_b_o (rd_addr_b_o),
    .cw_addr_o   (cw_addr_o),
    .wr_en_o     (wr_en_o),
    .wr_addr_a_o (wr_addr_a_o),
    .wr_addr_b_o (wr_addr_b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    int due;
    int a;
    int b;
  } wr_item_t;

  wr_item_t    sb[$];
  wr_item_t    it;
  bit          mon_en = 1'b0;
  int          m_stage, m_b, m_span, m_pos, m_ea, m_eb, m_ecw, m_idx;
  int          rd_count, done_count, first_rd, done_cyc, last_rd;
  int unsigned sig;
  int          obs_a  [TOTAL_RD];
  int          obs_b  [TOTAL_RD];
  int          obs_cw [TOTAL_RD];

  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_en_o) begin
        m_span = N >> (m_stage + 1);
        m_pos  = m_b % m_span;
        m_ea   = (m_b / m_span) * 2 * m_span + m_pos;
        m_eb   = m_ea + m_span;
        m_ecw  = m_pos * (1 << m_stage);
        if (rd_count == 0) first_rd = cyc;
        if (m_b == 0 && m_stage > 0) begin
          check("stage_gap", cyc - last_rd, PIPE_LAT + 1);
          check("writes_pending_at_next_stage", sb.size(), 0);
        end
        check("rd_stage", stage_o, m_stage);
        check("rd_addr_a", rd_addr_a_o, m_ea);
        check("rd_addr_b", rd_addr_b_o, m_eb);
        check("cw_addr", cw_addr_o, m_ecw);
        check("busy_in_run", busy_o, 1);
        m_idx = m_stage * (N / 2) + m_b;
        if (m_idx < TOTAL_RD) begin
          obs_a[m_idx]  = rd_addr_a_o;
          obs_b[m_idx]  = rd_addr_b_o;
          obs_cw[m_idx] = cw_addr_o;
        end
        sig = sig * 33 ^ {17'd0, rd_addr_a_o, rd_addr_b_o, cw_addr_o};
        sb.push_back('{due: cyc + PIPE_LAT, a: m_ea, b: m_eb});
        rd_count++;
        last_rd = cyc;
        m_b++;
        if (m_b == N / 2) begin
          m_b = 0;
          m_stage++;
        end
      end else begin
        check("cw_addr_without_rd", cw_addr_o, 0);
      end
      if (wr_en_o) begin
        if (sb.size() == 0) begin
          check("wr_en_unexpected", wr_en_o, 0);
        end else begin
          it = sb.pop_front();
          check("wr_cycle", cyc, it.due);
          check("wr_addr_a", wr_addr_a_o, it.a);
          check("wr_addr_b", wr_addr_b_o, it.b);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("wr_en_missing", wr_en_o, 1);
        void'(sb.pop_front());
      end
      if (done_o) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic pulse_start(output int sc);
    sc    = cyc;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic arm_monitor();
    m_stage    = 0;
    m_b        = 0;
    rd_count   = 0;
    done_count = 0;
    first_rd   = -1;
    done_cyc   = -1;
    last_rd    = 0;
    sig        = 0;
    sb.delete();
    mon_en     = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_count == 0 && k < budget) begin
      step(1);
      k++;
    end
    if (done_count == 0) check("done_timeout", done_count, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ":busy"},      busy_o,      0);
    check({tag, ":done"},      done_o,      0);
    check({tag, ":stage"},     stage_o,     0);
    check({tag, ":rd_en"},     rd_en_o,     0);
    check({tag, ":rd_addr_a"}, rd_addr_a_o, 0);
    check({tag, ":rd_addr_b"}, rd_addr_b_o, 0);
    check({tag, ":cw_addr"},   cw_addr_o,   0);
    check({tag, ":wr_en"},     wr_en_o,     0);
    check({tag, ":wr_addr_a"}, wr_addr_a_o, 0);
    check({tag, ":wr_addr_b"}, wr_addr_b_o, 0);
  endtask

  task automatic check_run_totals(input string tag, input int sc);
    check({tag, ":first_rd_latency"}, first_rd - sc, 1);
    check({tag, ":done_latency"},     done_cyc - first_rd, RUN_CYC);
    check({tag, ":rd_count"},         rd_count, TOTAL_RD);
    check({tag, ":done_pulses"},      done_count, 1);
    check({tag, ":scoreboard_empty"}, sb.size(), 0);
  endtask

  // ---------------- address vector table ----------------
  typedef struct {
    int stg;
    int b;
    int a;
    int bb;
    int cw;
  } vec_t;

  vec_t vecs[10];

  int          sc, f;
  int unsigned sig_run1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0,   0,   0, 128,   0};
    vecs[1] = '{0,   5,   5, 133,   5};
    vecs[2] = '{0, 127, 127, 255, 127};
    vecs[3] = '{1,  64, 128, 192,   0};
    vecs[4] = '{1,  70, 134, 198,  12};
    vecs[5] = '{7,   3,   6,   7,   0};
    vecs[6] = '{2, 127, 223, 255, 124};
    vecs[7] = '{6,  33,  65,  67,  64};
    vecs[8] = '{3,  20,  36,  52,  32};
    vecs[9] = '{7, 127, 254, 255,   0};

    reset_n = 1'b0;
    start   = 1'b0;

    // Reset held low while start toggles: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      step(1);
      check_quiet("reset_hold");
    end
    start   = 1'b0;
    reset_n = 1'b1;
    step(5);
    check_quiet("idle_after_reset");

    // Run 1: one clean transform.
    arm_monitor();
    pulse_start(sc);
    wait_done(RUN_CYC + 50);
    step(6);
    check_run_totals("run1", sc);
    check_quiet("idle_after_run1");
    for (int i = 0; i < 10; i++) begin
      check($sformatf("vec%0d_addr_a", i), obs_a[vecs[i].stg * (N / 2) + vecs[i].b], vecs[i].a);
      check($sformatf("vec%0d_addr_b", i), obs_b[vecs[i].stg * (N / 2) + vecs[i].b], vecs[i].bb);
      check($sformatf("vec%0d_cw", i),     obs_cw[vecs[i].stg * (N / 2) + vecs[i].b], vecs[i].cw);
    end
    sig_run1 = sig;

    // Run 2: start pulses in RUN, DRAIN and DONE must be ignored.
    arm_monitor();
    pulse_start(sc);
    f = sc + 1;
    step_to(f + 10);
    check("run2:busy_mid_run", busy_o, 1);
    pulse_start(sc);
    step_to(f + N / 2);
    check("run2:busy_in_drain", busy_o, 1);
    check("run2:rd_en_in_drain", rd_en_o, 0);
    pulse_start(sc);
    step_to(f + RUN_CYC);
    check("run2:done_at_cycle", done_o, 1);
    check("run2:busy_in_done", busy_o, 0);
    check("run2:stage_in_done", stage_o, LOG2N - 1);
    pulse_start(sc);
    for (int i = 0; i < 5; i++) begin
      check("run2:busy_after_done_start", busy_o, 0);
      check("run2:rd_en_after_done_start", rd_en_o, 0);
      step(1);
    end
    check_run_totals("run2", f - 1);
    check("run2:repeat_signature", sig, sig_run1);
    check_quiet("idle_after_run2");

    // Run 3: abort with reset in the middle of the stage 3 drain.
    arm_monitor();
    pulse_start(sc);
    f = sc + 1;
    step_to(f + 3 * STAGE_CYC + N / 2 + 1);
    check("run3:stage_before_abort", stage_o, 3);
    check("run3:rd_en_in_drain", rd_en_o, 0);
    check("run3:busy_before_abort", busy_o, 1);
    mon_en = 1'b0;
    sb.delete();
    #1 reset_n = 1'b0;
    #1 check_quiet("abort_immediate");
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_quiet("abort_hold");
    end
    check("run3:no_done_before_abort", done_count, 0);
    reset_n = 1'b1;
    step(2);
    check_quiet("idle_after_abort");
    arm_monitor();
    pulse_start(sc);
    wait_done(RUN_CYC + 50);
    step(6);
    check_run_totals("run3", sc);
    check("run3:restart_addr_a", obs_a[0], 0);
    check("run3:restart_addr_b", obs_b[0], 128);
    check_quiet("idle_after_run3");

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fft_addr_ctrl
